pn_driver: RTL and testbench
============================

# pn_driver

Initiator for the Polish Notation (PN) evaluator token interface. It accepts a whole expression frame in parallel over a valid/ready request port and serializes it, one token per cycle, onto the evaluator's `mode/operator/in/in_valid` inputs. It then captures the evaluator's `out_valid/out` result burst into a response register and returns the results over a valid/ready response port. It sits between a host or test sequencer and the PN evaluator.

## Interface
- `MAX_TOK`, 12, maximum tokens per frame
- `MAX_RES`, 4, maximum results captured per frame
- `TIMEOUT`, 64, idle cycles allowed in WAIT before abort (see Configuration)
- `clk` in 1: the single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: request frame valid
- `req_ready` out 1: high only in IDLE while `rst`=0
- `req_mode` in 2: 0 prefix/descending, 1 postfix/ascending, 2 prefix stack, 3 postfix stack
- `req_len` in 4: token count, legal 1..MAX_TOK
- `req_op` in MAX_TOK: bit i = 1 if token i is an operator
- `req_val` in 3*MAX_TOK: token i at [3i+2:3i]; operator codes 0 add, 1 sub, 2 mul, 3 abs(a+b)
- `pn_mode` out 2, `pn_operator` out 1, `pn_in` out 3, `pn_in_valid` out 1: evaluator inputs
- `pn_out_valid` in 1, `pn_out` in 32 signed: evaluator results
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake
- `rsp_cnt` out 3: results captured, 0..MAX_RES
- `rsp_data` out 32*MAX_RES: result k at [32k+31:32k], signed
- `rsp_err` out 1: length error or count mismatch/overflow
- `rsp_timeout` out 1: WAIT aborted
- `busy` out 1: state != IDLE

## Operation
- States: IDLE, SEND, WAIT, COLLECT, DONE.
- IDLE: `req_valid && req_ready` latches the frame and clears the token index, result count and flags.
  - Legal `req_len`: go to SEND.
  - `req_len`=0 or >MAX_TOK: go directly to DONE with `rsp_err`=1, `rsp_cnt`=0. No tokens are sent.
- SEND: each cycle drives token idx: `pn_in_valid`=1, `pn_operator`=op[idx], `pn_in`=val[idx], `pn_mode`=latched mode. Token 0 goes first. After token len-1, go to WAIT.
- WAIT: `pn_in_valid`=0. The first `pn_out_valid`=1 captures `pn_out` as result 0 and moves to COLLECT.
- COLLECT:
  - Each `pn_out_valid`=1 cycle stores `pn_out` at index `rsp_cnt` and increments `rsp_cnt`.
  - Pulses beyond MAX_RES are dropped and set `rsp_err`; `rsp_cnt` saturates at MAX_RES.
  - The first cycle with `pn_out_valid`=0 goes to DONE.
- Expected count: len/3 (integer division) for modes 0/1, 1 for modes 2/3. In DONE, `rsp_cnt` != expected sets `rsp_err`.
- DONE: `rsp_valid`=1. `rsp_data`, `rsp_cnt` and the flags are held stable until `rsp_ready`=1, then the block returns to IDLE.
- `pn_mode`, `pn_operator` and `pn_in` read 0 whenever `pn_in_valid`=0.
- Reset mid-frame: the next edge returns to IDLE and clears all outputs. The evaluator sees a truncated frame, which is accepted behaviour.

## Timing
- All outputs are registered except `req_ready`, which is decoded from the state register.
- Reset values: every output is 0; `req_ready` reads 0 while `rst`=1.
- Request accepted at edge T: tokens appear at cycles T+1..T+len, and `pn_in_valid` falls at T+len+1.
- Consecutive tokens have no gap. Back-to-back frames are separated by at least WAIT+COLLECT+DONE, which guarantees the evaluator sees `pn_in_valid` low between frames.
- A result sampled at edge E is visible in `rsp_data` after E. `rsp_valid` rises one cycle after the last result pulse.
- Illegal length: `rsp_valid` at T+1.
- `req_ready` returns 1 the cycle after the response handshake.
- `pn_out_valid` during SEND is ignored.

## Configuration
- `PN_DRV_TIMEOUT_EN` defined:
  - WAIT counts cycles with `pn_out_valid`=0.
  - When the count reaches TIMEOUT, go to DONE with `rsp_timeout`=1 and `rsp_cnt`=0; `rsp_err` is not set.
- Undefined: WAIT waits indefinitely, `rsp_timeout` is tied 0, and the counter is not built.

## Structure
- Package `pn_pkg` holds:
  - the state enum;
  - the mode constants (PREFIX_SORT, POSTFIX_SORT, PREFIX_STACK, POSTFIX_STACK);
  - the operator codes ADD/SUB/MUL/ABS_ADD;
  - the MAX_TOK and MAX_RES defaults.
- Sub-module `pn_drv_collect` contains the result capture register, saturating count, overflow flag and expected-count compare. The FSM and serializer stay in the top level.

## Test plan
- Mode 3, len 3, vals 3,4,0, ops 0,0,1 -> three tokens at T+1..T+3; the model returns 7 -> `rsp_cnt`=1, `rsp_data[31:0]`=7, `rsp_err`=0.
- Mode 0, len 6, tokens "+ 1 2 * 3 3" -> the model returns 9 then 3 -> `rsp_cnt`=2, result0=9, result1=3, `rsp_err`=0.
- `req_len`=0, then `req_len`=13 -> `pn_in_valid` is never asserted; `rsp_valid` at T+1 with `rsp_err`=1 and `rsp_cnt`=0 each time.
- Silent responder, TIMEOUT=64, macro defined -> `rsp_timeout`=1 64 cycles after WAIT entry. Macro undefined -> `busy` stays 1 for 200 cycles.
- Mode 0 with a model returning 5 pulses -> `rsp_cnt`=4 and `rsp_err`=1. Separately, hold `rsp_ready` low for 10 cycles -> outputs stable and `req_ready`=0; after the handshake, `req_ready`=1 on the next cycle.
- Assert `rst` after the 2nd token of a len-9 frame -> on the next cycle `pn_in_valid`, `busy` and `rsp_valid` are all 0. After release, `req_ready`=1 and a new frame completes normally.

Source files
------------

// File: rtl/pn_pkg.sv
// rtl/pn_pkg.sv - shared states, mode/operator codes and sizing defaults for the PN driver
package pn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    COLLECT,
    DONE
  } pn_state_e;

  localparam logic [1:0] PREFIX_SORT   = 2'd0;
  localparam logic [1:0] POSTFIX_SORT  = 2'd1;
  localparam logic [1:0] PREFIX_STACK  = 2'd2;
  localparam logic [1:0] POSTFIX_STACK = 2'd3;

  localparam logic [2:0] ADD     = 3'd0;
  localparam logic [2:0] SUB     = 3'd1;
  localparam logic [2:0] MUL     = 3'd2;
  localparam logic [2:0] ABS_ADD = 3'd3;

  localparam int MAX_TOK_DEF = 12;
  localparam int MAX_RES_DEF = 4;

  // Sort modes emit one result per operator triple; stack modes emit a single value.
  function automatic logic [2:0] expected_cnt(input logic [1:0] mode, input logic [3:0] len);
    if (mode == PREFIX_STACK || mode == POSTFIX_STACK) begin
      return 3'd1;
    end
    return 3'(len / 4'd3);
  endfunction

endpackage

// File: rtl/pn_drv_collect.sv
// rtl/pn_drv_collect.sv - result capture register with saturating count and error flag
module pn_drv_collect
  import pn_pkg::*;
#(
  parameter int MAX_RES = MAX_RES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  set_err,
  input  logic                  cap,
  input  logic                  chk,
  input  logic [2:0]            exp_cnt,
  input  logic [31:0]           din,
  output logic [32*MAX_RES-1:0] rsp_data,
  output logic [2:0]            rsp_cnt,
  output logic                  rsp_err
);

  // Store each result in the next free slot; extra pulses only raise the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_cnt  <= '0;
      rsp_err  <= 1'b0;
    end else if (clr) begin
      rsp_data <= '0;
      rsp_cnt  <= '0;
      rsp_err  <= set_err;
    end else begin
      if (cap) begin
        if (rsp_cnt < 3'(MAX_RES)) begin
          for (int k = 0; k < MAX_RES; k++) begin
            if (rsp_cnt == 3'(k)) begin
              rsp_data[32*k +: 32] <= din;
            end
          end
          rsp_cnt <= rsp_cnt + 3'd1;
        end else begin
          rsp_err <= 1'b1;
        end
      end
      if (chk && (rsp_cnt != exp_cnt)) begin
        rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pn_driver.sv
// rtl/pn_driver.sv - PN evaluator initiator: token serializer, result collector; WAIT timeout under PN_DRV_TIMEOUT_EN
module pn_driver
  import pn_pkg::*;
#(
  parameter int MAX_TOK = MAX_TOK_DEF,
  parameter int MAX_RES = MAX_RES_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_mode,
  input  logic [3:0]            req_len,
  input  logic [MAX_TOK-1:0]    req_op,
  input  logic [3*MAX_TOK-1:0]  req_val,
  output logic [1:0]            pn_mode,
  output logic                  pn_operator,
  output logic [2:0]            pn_in,
  output logic                  pn_in_valid,
  input  logic                  pn_out_valid,
  input  logic signed [31:0]    pn_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2:0]            rsp_cnt,
  output logic [32*MAX_RES-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy
);

  pn_state_e            state, state_d;
  logic [1:0]           mode_q;
  logic [3:0]           len_q;
  logic [MAX_TOK-1:0]   op_q;
  logic [3*MAX_TOK-1:0] val_q;
  logic [3:0]           idx, idx_d;
  logic                 in_valid_d, op_d;
  logic [1:0]           mode_d;
  logic [2:0]           in_d;
  logic                 sel_op;
  logic [2:0]           sel_val;
  logic                 accept, len_ok, cap, chk, tmo_hit;
  logic [2:0]           exp_cnt;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign len_ok    = (req_len != 4'd0) && (req_len <= 4'(MAX_TOK));
  assign cap       = pn_out_valid && ((state == WAIT) || (state == COLLECT));
  assign chk       = (state == COLLECT) && !pn_out_valid;
  assign exp_cnt   = expected_cnt(mode_q, len_q);

  // Pick the latched token addressed by the serializer index.
  always_comb begin
    sel_op  = 1'b0;
    sel_val = 3'd0;
    for (int i = 0; i < MAX_TOK; i++) begin
      if (idx == 4'(i)) begin
        sel_op  = op_q[i];
        sel_val = val_q[3*i +: 3];
      end
    end
  end

  // Next state and next evaluator-side token; token 0 comes straight from the request.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    in_valid_d = 1'b0;
    mode_d     = 2'd0;
    op_d       = 1'b0;
    in_d       = 3'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (len_ok) begin
            state_d    = SEND;
            idx_d      = 4'd1;
            in_valid_d = 1'b1;
            mode_d     = req_mode;
            op_d       = req_op[0];
            in_d       = req_val[2:0];
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (idx == len_q) begin
          state_d = WAIT;
        end else begin
          idx_d      = idx + 4'd1;
          in_valid_d = 1'b1;
          mode_d     = mode_q;
          op_d       = sel_op;
          in_d       = sel_val;
        end
      end
      WAIT: begin
        if (pn_out_valid) begin
          state_d = COLLECT;
        end else if (tmo_hit) begin
          state_d = DONE;
        end
      end
      COLLECT: begin
        if (!pn_out_valid) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, frame latch and registered evaluator/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      mode_q      <= '0;
      len_q       <= '0;
      op_q        <= '0;
      val_q       <= '0;
      pn_in_valid <= 1'b0;
      pn_mode     <= '0;
      pn_operator <= 1'b0;
      pn_in       <= '0;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      pn_in_valid <= in_valid_d;
      pn_mode     <= mode_d;
      pn_operator <= op_d;
      pn_in       <= in_d;
      rsp_valid   <= (state_d == DONE);
      busy        <= (state_d != IDLE);
      if (accept) begin
        mode_q <= req_mode;
        len_q  <= req_len;
        op_q   <= req_op;
        val_q  <= req_val;
      end
    end
  end

`ifdef PN_DRV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;

  assign tmo_hit     = (state == WAIT) && !pn_out_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign rsp_timeout = tmo_q;

  // Count silent WAIT cycles; the flag sticks until the next frame is accepted.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if ((state == WAIT) && !pn_out_valid) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) begin
        tmo_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  pn_drv_collect #(
    .MAX_RES (MAX_RES)
  ) u_collect (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .set_err  (accept && !len_ok),
    .cap      (cap),
    .chk      (chk),
    .exp_cnt  (exp_cnt),
    .din      (pn_out),
    .rsp_data (rsp_data),
    .rsp_cnt  (rsp_cnt),
    .rsp_err  (rsp_err)
  );

endmodule

// File: tb/tb_pn_driver.sv
// tb/tb_pn_driver.sv - randomized self-checking bench for pn_driver against a frame-level model
module tb_pn_driver;
  import pn_pkg::*;

  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_mode;
  logic [3:0]    req_len;
  logic [11:0]   req_op;
  logic [35:0]   req_val;
  logic [1:0]    pn_mode;
  logic          pn_operator;
  logic [2:0]    pn_in;
  logic          pn_in_valid;
  logic          pn_out_valid;
  logic signed [31:0] pn_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [2:0]    rsp_cnt;
  logic [127:0]  rsp_data;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_idle = 0;
  int tok_base;
  int t_acc;
  logic [5:0]  tok_q[$];
  int          tcyc_q[$];
  logic [31:0] resp_vals[8];

  pn_driver #(.MAX_TOK(12), .MAX_RES(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_len(req_len), .req_op(req_op), .req_val(req_val),
    .pn_mode(pn_mode), .pn_operator(pn_operator), .pn_in(pn_in), .pn_in_valid(pn_in_valid),
    .pn_out_valid(pn_out_valid), .pn_out(pn_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_cnt(rsp_cnt), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every token the evaluator would see, and any non-zero token field while idle.
  always @(negedge clk) begin
    if (!rst) begin
      if (pn_in_valid) begin
        tok_q.push_back({pn_mode, pn_operator, pn_in});
        tcyc_q.push_back(cyc);
      end else if ({pn_mode, pn_operator, pn_in} != 6'd0) begin
        bad_idle++;
      end
    end
  end

  task automatic send_req(input logic [1:0] m, input logic [3:0] l, input logic [11:0] op,
                          input logic [35:0] v);
    int w;
    @(negedge clk);
    req_mode = m; req_len = l; req_op = op; req_val = v; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_wait got %b exp 1", req_ready); end
    tok_base = tok_q.size();
    @(negedge clk);
    t_acc = cyc;
    req_valid = 1'b0; req_mode = '0; req_len = '0; req_op = '0; req_val = '0;
  endtask

  task automatic respond(input int dly, input int n, input bit junk);
    int w;
    w = 0;
    while (pn_in_valid && w < 100) begin
      pn_out_valid = junk; pn_out = 32'hdeadbeef;
      @(negedge clk); w++;
    end
    pn_out_valid = 1'b0; pn_out = '0;
    checks++;
    if (pn_in_valid !== 1'b0) begin errors++; $display("FAIL send_end got %b exp 0", pn_in_valid); end
    repeat (dly) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      pn_out_valid = 1'b1; pn_out = resp_vals[i];
      @(negedge clk);
    end
    pn_out_valid = 1'b0; pn_out = '0;
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [3:0] l, input logic [11:0] op,
                           input logic [35:0] v, input int dly, input int n, input bit junk,
                           input int stall);
    bit legal;
    int ncap, ecnt, ntok;
    bit eerr;
    legal = (l >= 1) && (l <= 12);
    ncap  = (n > 4) ? 4 : n;
    if (!legal) begin
      ecnt = 0; eerr = 1'b1;
    end else begin
      ecnt = ncap;
      eerr = (n > 4) || (ncap != ((m >= 2) ? 1 : int'(l) / 3));
    end
    send_req(m, l, op, v);
    if (legal) begin
      respond(dly, n, junk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_valid_early got %b exp 0", rsp_valid); end
      @(negedge clk);
    end
    ntok = tok_q.size() - tok_base;
    checks++;
    if (ntok != (legal ? int'(l) : 0)) begin
      errors++; $display("FAIL token_count got %0d exp %0d", ntok, legal ? int'(l) : 0);
    end else begin
      for (int i = 0; i < ntok; i++) begin
        checks++;
        if (tok_q[tok_base+i] !== {m, op[i], v[3*i +: 3]} || tcyc_q[tok_base+i] != t_acc + i) begin
          errors++;
          $display("FAIL token%0d got %h@%0d exp %h@%0d", i, tok_q[tok_base+i], tcyc_q[tok_base+i],
                   {m, op[i], v[3*i +: 3]}, t_acc + i);
        end
      end
    end
    checks++;
    if (bad_idle != 0) begin errors++; $display("FAIL idle_token_zero got %0d exp 0", bad_idle); end
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if ({rsp_valid, busy, req_ready, rsp_timeout} !== 4'b1100) begin
        errors++; $display("FAIL done_flags got %b exp 1100", {rsp_valid, busy, req_ready, rsp_timeout});
      end
      checks++;
      if (rsp_cnt !== 3'(ecnt)) begin errors++; $display("FAIL rsp_cnt got %0d exp %0d", rsp_cnt, ecnt); end
      checks++;
      if (rsp_err !== eerr) begin errors++; $display("FAIL rsp_err got %b exp %b", rsp_err, eerr); end
      for (int k = 0; k < ecnt; k++) begin
        checks++;
        if (rsp_data[32*k +: 32] !== resp_vals[k]) begin
          errors++; $display("FAIL rsp_data%0d got %h exp %h", k, rsp_data[32*k +: 32], resp_vals[k]);
        end
      end
      if (s < stall) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL after_handshake got %b exp 100", {req_ready, rsp_valid, busy});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 0; req_mode = 0; req_len = 0; req_op = 0; req_val = 0;
    pn_out_valid = 0; pn_out = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, pn_mode, pn_operator, pn_in, pn_in_valid, rsp_valid, rsp_cnt, rsp_err,
         rsp_timeout, busy} !== 15'd0 || rsp_data !== 128'd0) begin
      errors++; $display("FAIL reset_outputs got nonzero exp 0");
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_directed;
    resp_vals[0] = 32'd7;
    run_frame(POSTFIX_STACK, 4'd3, 12'b100, {27'd0, ADD, 3'd4, 3'd3}, 0, 1, 1'b0, 0);
    resp_vals[0] = 32'd9; resp_vals[1] = 32'd3;
    run_frame(PREFIX_SORT, 4'd6, 12'b001001, {18'd0, 3'd3, 3'd3, MUL, 3'd2, 3'd1, ADD}, 2, 2, 1'b1, 0);
    resp_vals[0] = 32'd3;
    run_frame(PREFIX_STACK, 4'd3, 12'b001, {27'd0, 3'd2, 3'd1, ABS_ADD}, 1, 1, 1'b0, 0);
    resp_vals[0] = 32'hfffffffd;
    run_frame(POSTFIX_STACK, 4'd3, 12'b100, {27'd0, SUB, 3'd5, 3'd2}, 0, 1, 1'b0, 0);
  endtask

  task automatic test_bad_len;
    run_frame(PREFIX_SORT, 4'd0, 12'hfff, 36'hfffffffff, 0, 0, 1'b0, 0);
    run_frame(POSTFIX_SORT, 4'd13, 12'hfff, 36'hfffffffff, 0, 0, 1'b0, 0);
  endtask

  task automatic test_overflow_stall;
    logic [63:0] r;
    for (int i = 0; i < 5; i++) resp_vals[i] = $urandom;
    r = {$urandom, $urandom};
    run_frame(PREFIX_SORT, 4'd12, 12'($urandom), r[35:0], 0, 5, 1'b0, 0);
    r = {$urandom, $urandom};
    run_frame(POSTFIX_SORT, 4'd9, 12'($urandom), r[35:0], 1, 3, 1'b0, 10);
  endtask

  task automatic test_random;
    logic [63:0] r;
    logic [3:0]  l;
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 8; i++) resp_vals[i] = $urandom;
      r = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(13, 15));
      else l = 4'($urandom_range(1, 12));
      run_frame(2'($urandom_range(0, 3)), l, 12'($urandom), r[35:0], $urandom_range(0, 3),
                $urandom_range(1, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_timeout;
    int w, t_wait;
    bit stayed;
    send_req(POSTFIX_SORT, 4'd3, 12'b100, {27'd0, ADD, 3'd1, 3'd1});
    w = 0;
    while (pn_in_valid && w < 50) begin @(negedge clk); w++; end
    t_wait = cyc;
`ifdef PN_DRV_TIMEOUT_EN
    w = 0;
    while (!rsp_valid && w < 200) begin @(negedge clk); w++; end
    checks++;
    if (cyc != t_wait + TO) begin errors++; $display("FAIL timeout_cycle got %0d exp %0d", cyc, t_wait + TO); end
    checks++;
    if ({rsp_valid, rsp_timeout, rsp_err, rsp_cnt} !== 6'b110000) begin
      errors++; $display("FAIL timeout_flags got %b exp 110000", {rsp_valid, rsp_timeout, rsp_err, rsp_cnt});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL timeout_release got %b exp 10", {req_ready, rsp_valid}); end
`else
    stayed = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (busy !== 1'b1 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) stayed = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stayed) begin errors++; $display("FAIL wait_forever got early exit exp busy for 200 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wait_recover got %b exp 1", req_ready); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [63:0] r;
    r = {$urandom, $urandom};
    send_req(PREFIX_SORT, 4'd9, 12'($urandom), r[35:0]);
    @(negedge clk);
    checks++;
    if (pn_in_valid !== 1'b1) begin errors++; $display("FAIL mid_token got %b exp 1", pn_in_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pn_in_valid, busy, rsp_valid, req_ready} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset got %b exp 0000", {pn_in_valid, busy, rsp_valid, req_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_release got %b exp 1", req_ready); end
    for (int i = 0; i < 3; i++) resp_vals[i] = $urandom;
    r = {$urandom, $urandom};
    run_frame(POSTFIX_SORT, 4'd9, 12'($urandom), r[35:0], 1, 3, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_len();
    test_overflow_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

endmodule
